exp_table_bank: RTL and testbench
=================================

Name: exp_table_bank

Overview:
Receiving end of the exponent-table write stream (addr, data, valid) produced by the ExpMu/ExpSigma generators.
Holds two RAM banks in ping-pong: one bank fills from the generator stream while the MC core reads the other.
Tracks fill completeness per address, swaps banks on the core-start pulse, and serves 1-cycle-latency reads.
One instance per table (ExpMu: DEPTH 512, ADDR_W 9; ExpSigma: DEPTH 588, ADDR_W 10).

Parameters:
ADDR_W, 9, width of write and read addresses
DATA_W, 18, table entry width
DEPTH, 512, number of valid entries per bank; DEPTH <= 2^ADDR_W

Ports:
CLK  input  1  clock, all logic on posedge
RST  input  1  synchronous active-high reset
iWrStart  input  1  pulse: begin a new fill of the write bank
iWrAddr  input  ADDR_W  write address
iWrData  input  DATA_W  write data
iWrValid  input  1  write strobe
iSwap  input  1  pulse: exchange write/read banks (driven by core start)
iRdEn  input  1  read request
iRdAddr  input  ADDR_W  read address
oRdData  output  DATA_W  read data
oRdValid  output  1  oRdData valid
oWrBank  output  1  index of bank currently being written
oFillCount  output  ADDR_W+1  distinct addresses written in current fill
oFull  output  1  write bank holds all DEPTH entries
oRdReady  output  1  read bank holds a complete table
oErr  output  1  sticky protocol-error flag, cleared only by RST

Behaviour:
- Reset (RST=1 on a clock edge): state IDLE, oWrBank=0, oFillCount=0, oFull=0, oRdReady=0, oRdValid=0, oRdData=0, oErr=0, written-bitmap cleared. RAM contents are not reset.
- State machine, write side:
  - IDLE --iWrStart--> FILL: bitmap and count cleared.
  - FILL --count reaches DEPTH--> FULL: oFull=1 in the cycle after the last new-address write.
  - FILL --iWrStart--> FILL: restart; bitmap and count cleared.
  - FULL --iSwap--> IDLE.
  - iWrStart in FULL: ignored, oErr set.
- Write acceptance: iWrValid only in FILL with iWrAddr < DEPTH.
  - Accepted write stores iWrData in bank oWrBank at iWrAddr.
  - New address: sets the bitmap bit and increments count.
  - Address already written in this fill: data overwritten, count unchanged, oErr set.
  - iWrValid in IDLE or FULL, or iWrAddr >= DEPTH: write ignored, oErr set.
  - iWrStart and iWrValid in the same cycle: restart takes effect; the write is ignored.
- Swap: iSwap in FULL toggles oWrBank, sets oRdReady=1, clears oFull/count/bitmap, goes to IDLE, all on the same edge.
  - iSwap in IDLE or FILL: ignored, oErr set, state and banks unchanged.
  - iSwap and iWrStart in the same cycle while FULL: swap, then enter FILL on the new write bank.
- Read side: synchronous, latency 1.
  - iRdEn at edge N with oRdReady=1 and iRdAddr < DEPTH: oRdValid=1 and oRdData = bank(~oWrBank)[iRdAddr] during cycle N+1.
  - Otherwise oRdValid=0 and oRdData=0.
  - A read sampled on the swap edge uses the pre-swap read bank.
  - oRdReady stays 1 after its first swap; there is no clear except RST.
- Write and read of different banks in the same cycle are independent (dual-port per bank, or two simple-dual-port RAMs).
- Mid-operation reset: fill aborts, oRdReady=0, and reads return invalid until the next full fill and swap.

Test Plan:
- Reset then iRdEn with addr 5 -> oRdValid=0, oRdData=0; oWrBank=0, oErr=0.
- iWrStart, then write addr i with data i+100 for i=0..511 in order -> oFillCount reaches 512; oFull=1 on the next cycle; oErr=0.
- From FULL, pulse iSwap, then read addr 0, 255, 511 -> one cycle later oRdValid=1 with data 100, 355, 611; oWrBank=1, oRdReady=1.
- Three interleaved writers (addrs 0..170, 171..341, 342..511) muxed round-robin -> oFull asserts only after the final distinct address; iSwap one cycle earlier -> ignored, oErr=1.
- Fill bank 1 with data i+200 while continuously reading bank 0 -> reads keep returning i+100; after swap, same addresses return i+200 beginning with reads issued the cycle after the swap edge.
- Duplicate write to addr 7, a write with addr >= DEPTH (DEPTH=500 build), and RST asserted mid-fill -> oErr=1, count not advanced by the first two, and after RST all outputs return to reset values.

Source files
------------

// File: rtl/exp_table_bank_if.sv
// exp_table_bank_if: bundles the generator write stream, the bank-swap pulse,
// the core read port and the status flags of one exponent-table bank pair.
//   master : drives iWrStart/iWrAddr/iWrData/iWrValid/iSwap/iRdEn/iRdAddr
//   slave  : drives oRdData/oRdValid/oWrBank/oFillCount/oFull/oRdReady/oErr
//            and oDbgState (current write-side state, for observation only)
//
// Handshake semantics: iWrValid is a one-cycle strobe with no backpressure;
// every asserted cycle is either accepted or flagged through oErr. iRdEn is a
// request sampled on the clock edge; oRdValid qualifies oRdData for exactly
// the following cycle, and oRdData is forced to zero whenever oRdValid is low.
interface exp_table_bank_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 18
);
  logic              iWrStart;
  logic [ADDR_W-1:0] iWrAddr;
  logic [DATA_W-1:0] iWrData;
  logic              iWrValid;
  logic              iSwap;
  logic              iRdEn;
  logic [ADDR_W-1:0] iRdAddr;
  logic [DATA_W-1:0] oRdData;
  logic              oRdValid;
  logic              oWrBank;
  logic [ADDR_W:0]   oFillCount;
  logic              oFull;
  logic              oRdReady;
  logic              oErr;
  logic [1:0]        oDbgState;

  modport master (
    output iWrStart, iWrAddr, iWrData, iWrValid, iSwap, iRdEn, iRdAddr,
    input  oRdData, oRdValid, oWrBank, oFillCount, oFull, oRdReady, oErr,
           oDbgState
  );

  modport slave (
    input  iWrStart, iWrAddr, iWrData, iWrValid, iSwap, iRdEn, iRdAddr,
    output oRdData, oRdValid, oWrBank, oFillCount, oFull, oRdReady, oErr,
           oDbgState
  );
endinterface

// File: rtl/exp_table_bank.sv
// exp_table_bank: ping-pong pair of exponent-table RAM banks. The generator
// stream fills bank oWrBank while the MC core reads the other bank with a
// one-cycle latency. A per-address bitmap tracks fill completeness; the
// core-start pulse (iSwap) exchanges the banks once the write bank is full.
// Ports:
//   CLK  : clock, all logic on posedge
//   RST  : synchronous active-high reset (RAM contents are not cleared)
//   bus  : exp_table_bank_if.slave (write stream, swap, read port, status)
module exp_table_bank #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 18,
  parameter int DEPTH  = 512
) (
  input  logic             CLK,
  input  logic             RST,
  exp_table_bank_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem0_q [DEPTH];
  logic [DATA_W-1:0] mem1_q [DEPTH];

  logic [1:0]        state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W:0]   fill_cnt_q, fill_cnt_d;
  logic [DEPTH-1:0]  bitmap_q, bitmap_d;
  logic              rd_ready_q, rd_ready_d;
  logic              err_q, err_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic wr_in_range, rd_in_range, wr_en, rd_hit;

  assign wr_in_range = {1'b0, bus.iWrAddr} < DEPTH_L;
  assign rd_in_range = {1'b0, bus.iRdAddr} < DEPTH_L;
  // A restart in the same cycle wins over the write; duplicates still store.
  assign wr_en  = (state_q == ST_FILL) && bus.iWrValid && !bus.iWrStart &&
                  wr_in_range && !RST;
  assign rd_hit = bus.iRdEn && rd_ready_q && rd_in_range;

  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    fill_cnt_d = fill_cnt_q;
    bitmap_d   = bitmap_q;
    rd_ready_d = rd_ready_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.iSwap) err_d = 1'b1;
        if (bus.iWrStart) begin
          state_d    = ST_FILL;
          fill_cnt_d = '0;
          bitmap_d   = '0;
        end else if (bus.iWrValid) begin
          err_d = 1'b1;
        end
      end
      ST_FILL: begin
        if (bus.iSwap) err_d = 1'b1;
        if (bus.iWrStart) begin
          fill_cnt_d = '0;
          bitmap_d   = '0;
        end else if (bus.iWrValid) begin
          if (!wr_in_range || bitmap_q[bus.iWrAddr]) begin
            err_d = 1'b1;
          end else begin
            bitmap_d[bus.iWrAddr] = 1'b1;
            fill_cnt_d            = fill_cnt_q + ONE;
            if (fill_cnt_q + ONE == DEPTH_L) state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (bus.iWrValid) err_d = 1'b1;
        if (bus.iSwap) begin
          // Swap and an optional simultaneous start land on the same edge:
          // the new write bank begins filling immediately.
          wr_bank_d  = ~wr_bank_q;
          rd_ready_d = 1'b1;
          fill_cnt_d = '0;
          bitmap_d   = '0;
          state_d    = bus.iWrStart ? ST_FILL : ST_IDLE;
        end else if (bus.iWrStart) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      wr_bank_q  <= 1'b0;
      fill_cnt_q <= '0;
      bitmap_q   <= '0;
      rd_ready_q <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      fill_cnt_q <= fill_cnt_d;
      bitmap_q   <= bitmap_d;
      rd_ready_q <= rd_ready_d;
      err_q      <= err_d;
      rd_valid_q <= rd_hit;
    end
  end

  // RAM write port: no reset on the storage itself.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      if (wr_bank_q) mem1_q[bus.iWrAddr] <= bus.iWrData;
      else           mem0_q[bus.iWrAddr] <= bus.iWrData;
    end
  end

  // Read port uses the pre-edge bank index, so a read on the swap edge
  // still returns data from the outgoing read bank.
  always_ff @(posedge CLK) begin
    if (RST || !rd_hit) rd_data_q <= '0;
    else if (wr_bank_q) rd_data_q <= mem0_q[bus.iRdAddr];
    else                rd_data_q <= mem1_q[bus.iRdAddr];
  end

  assign bus.oRdData    = rd_data_q;
  assign bus.oRdValid   = rd_valid_q;
  assign bus.oWrBank    = wr_bank_q;
  assign bus.oFillCount = fill_cnt_q;
  assign bus.oFull      = (state_q == ST_FULL);
  assign bus.oRdReady   = rd_ready_q;
  assign bus.oErr       = err_q;
  assign bus.oDbgState  = state_q;

endmodule

// File: tb/tb_exp_table_bank.sv
// Bench for exp_table_bank: instance A (DEPTH 512) is checked every cycle
// against a behavioural table model; instance B (DEPTH 500) covers protocol
// errors, out-of-range addresses and mid-fill reset with directed checks.
module tb_exp_table_bank;
  localparam int AW = 9;
  localparam int DW = 18;
  localparam int DA = 512;
  localparam int DB = 500;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b;

  exp_table_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  exp_table_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  exp_table_bank #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DA)) dut_a (
    .CLK(clk), .RST(rst_a), .bus(bus_a.slave));
  exp_table_bank #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DB)) dut_b (
    .CLK(clk), .RST(rst_b), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model for instance A ----------------
  typedef enum {PH_IDLE, PH_FILL, PH_FULL} phase_t;
  phase_t m_ph;
  bit     m_bank, m_rdy, m_err, m_rv;
  int     m_cnt, m_rd;
  bit     m_seen [DA];
  int     m_mem  [2][DA];

  function automatic void m_clear();
    m_cnt = 0;
    foreach (m_seen[i]) m_seen[i] = 1'b0;
  endfunction

  task automatic model_a();
    int wa;
    bit st, wv, sw;
    m_rv = bus_a.iRdEn && m_rdy && (int'(bus_a.iRdAddr) < DA);
    m_rd = m_rv ? m_mem[m_bank ? 0 : 1][bus_a.iRdAddr] : 0;
    if (rst_a) begin
      m_ph = PH_IDLE; m_bank = 0; m_rdy = 0; m_err = 0; m_rv = 0; m_rd = 0;
      m_clear();
      return;
    end
    st = bus_a.iWrStart; wv = bus_a.iWrValid; sw = bus_a.iSwap;
    wa = int'(bus_a.iWrAddr);
    case (m_ph)
      PH_IDLE: begin
        if (sw) m_err = 1;
        if (st) begin m_clear(); m_ph = PH_FILL; end
        else if (wv) m_err = 1;
      end
      PH_FILL: begin
        if (sw) m_err = 1;
        if (st) m_clear();
        else if (wv) begin
          if (wa >= DA) m_err = 1;
          else begin
            m_mem[m_bank][wa] = int'(bus_a.iWrData);
            if (m_seen[wa]) m_err = 1;
            else begin
              m_seen[wa] = 1; m_cnt++;
              if (m_cnt == DA) m_ph = PH_FULL;
            end
          end
        end
      end
      PH_FULL: begin
        if (wv) m_err = 1;
        if (sw) begin
          m_bank = !m_bank; m_rdy = 1; m_clear();
          m_ph = st ? PH_FILL : PH_IDLE;
        end else if (st) m_err = 1;
      end
      default: m_ph = PH_IDLE;
    endcase
  endtask

  task automatic check_a();
    chk("a_rd_valid", 32'(bus_a.oRdValid), 32'(m_rv));
    chk("a_rd_data", 32'(bus_a.oRdData), m_rd);
    chk("a_wr_bank", 32'(bus_a.oWrBank), 32'(m_bank));
    chk("a_fill_cnt", 32'(bus_a.oFillCount), m_cnt);
    chk("a_full", 32'(bus_a.oFull), 32'(m_ph == PH_FULL));
    chk("a_rd_ready", 32'(bus_a.oRdReady), 32'(m_rdy));
    chk("a_err", 32'(bus_a.oErr), 32'(m_err));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_a();
    #1;
    check_a();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_a();
    bus_a.iWrStart = 0; bus_a.iWrValid = 0; bus_a.iWrAddr = '0; bus_a.iWrData = '0;
    bus_a.iSwap = 0; bus_a.iRdEn = 0; bus_a.iRdAddr = '0;
  endtask

  task automatic idle_b();
    bus_b.iWrStart = 0; bus_b.iWrValid = 0; bus_b.iWrAddr = '0; bus_b.iWrData = '0;
    bus_b.iSwap = 0; bus_b.iRdEn = 0; bus_b.iRdAddr = '0;
  endtask

  task automatic wr_a(input int addr, input int data);
    bus_a.iWrValid = 1; bus_a.iWrAddr = AW'(addr); bus_a.iWrData = DW'(data);
  endtask

  task automatic rd_a(input int addr);
    bus_a.iRdEn = 1; bus_a.iRdAddr = AW'(addr);
  endtask

  task automatic wr_b(input int addr, input int data);
    bus_b.iWrValid = 1; bus_b.iWrAddr = AW'(addr); bus_b.iWrData = DW'(data);
    tick();
    bus_b.iWrValid = 0;
  endtask

  task automatic chk_b_reset(input string tag);
    chk({tag, "_rd_valid"}, 32'(bus_b.oRdValid), 0);
    chk({tag, "_rd_data"}, 32'(bus_b.oRdData), 0);
    chk({tag, "_wr_bank"}, 32'(bus_b.oWrBank), 0);
    chk({tag, "_fill_cnt"}, 32'(bus_b.oFillCount), 0);
    chk({tag, "_full"}, 32'(bus_b.oFull), 0);
    chk({tag, "_rd_ready"}, 32'(bus_b.oRdReady), 0);
    chk({tag, "_err"}, 32'(bus_b.oErr), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int order[$];
    int nxt[3], lim[3];
    int w, ra, tmp, j;
    int rd_list[3];

    idle_a(); idle_b();
    rst_a = 1; rst_b = 1;
    m_ph = PH_IDLE; m_bank = 0; m_rdy = 0; m_err = 0; m_rv = 0; m_rd = 0; m_clear();
    repeat (2) tick();
    rst_a = 0;

    // Reset state: read request before any table exists is rejected.
    rd_a(5); tick();
    chk("reset_rd_valid", 32'(bus_a.oRdValid), 0);
    chk("reset_rd_data", 32'(bus_a.oRdData), 0);
    chk("reset_wr_bank", 32'(bus_a.oWrBank), 0);
    chk("reset_err", 32'(bus_a.oErr), 0);
    idle_a();

    // Sequential fill of bank 0 with i+100.
    bus_a.iWrStart = 1; tick(); bus_a.iWrStart = 0;
    for (int i = 0; i < DA; i++) begin
      wr_a(i, i + 100); tick();
      if (i == DA - 2) chk("full_not_early", 32'(bus_a.oFull), 0);
    end
    idle_a();
    chk("fill1_count", 32'(bus_a.oFillCount), DA);
    chk("fill1_full", 32'(bus_a.oFull), 1);
    chk("fill1_err", 32'(bus_a.oErr), 0);

    // Swap, then read back boundary and middle entries.
    bus_a.iSwap = 1; tick(); bus_a.iSwap = 0;
    chk("swap1_wr_bank", 32'(bus_a.oWrBank), 1);
    chk("swap1_rd_ready", 32'(bus_a.oRdReady), 1);
    rd_list = '{0, 255, 511};
    for (int k = 0; k < 3; k++) begin
      rd_a(rd_list[k]); tick();
      chk("swap1_rd_valid", 32'(bus_a.oRdValid), 1);
      chk("swap1_rd_data", 32'(bus_a.oRdData), rd_list[k] + 100);
    end
    idle_a();

    // Three round-robin writers fill bank 1 with i+200 while bank 0 is read.
    nxt = '{0, 171, 342};
    lim = '{171, 342, 512};
    w = 0;
    order.delete();
    while (order.size() < DA) begin
      if (nxt[w] < lim[w]) begin order.push_back(nxt[w]); nxt[w]++; end
      w = (w + 1) % 3;
    end
    bus_a.iWrStart = 1; tick(); bus_a.iWrStart = 0;
    for (int idx = 0; idx < DA; idx++) begin
      if (idx == DA - 1) begin
        chk("rr_err_before_swap", 32'(bus_a.oErr), 0);
        bus_a.iWrValid = 0; bus_a.iSwap = 1;
        ra = $urandom_range(0, DA - 1); rd_a(ra);
        tick();
        bus_a.iSwap = 0;
        chk("early_swap_err", 32'(bus_a.oErr), 1);
        chk("early_swap_bank", 32'(bus_a.oWrBank), 1);
        chk("early_swap_full", 32'(bus_a.oFull), 0);
      end
      ra = $urandom_range(0, DA - 1); rd_a(ra);
      wr_a(order[idx], order[idx] + 200);
      tick();
      chk("rr_read_old", 32'(bus_a.oRdData), ra + 100);
    end
    bus_a.iWrValid = 0; bus_a.iRdEn = 0;
    chk("rr_full", 32'(bus_a.oFull), 1);

    // Read sampled on the swap edge sees the old bank; the next one the new.
    bus_a.iSwap = 1; rd_a(10); tick(); bus_a.iSwap = 0;
    chk("swap_edge_read", 32'(bus_a.oRdData), 110);
    rd_a(10); tick();
    chk("post_swap_read", 32'(bus_a.oRdData), 210);
    repeat (8) begin
      ra = $urandom_range(0, DA - 1); rd_a(ra); tick();
      chk("post_swap_rand", 32'(bus_a.oRdData), ra + 200);
    end
    idle_a();

    // Random-order, random-data fill of bank 0 with idle gaps and reads.
    order.delete();
    for (int i = 0; i < DA; i++) order.push_back(i);
    for (int i = DA - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    bus_a.iWrStart = 1; tick(); bus_a.iWrStart = 0;
    for (int idx = 0; idx < DA; idx++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus_a.iWrValid = 0; rd_a($urandom_range(0, DA - 1)); tick();
      end
      wr_a(order[idx], $urandom_range(0, (1 << DW) - 1));
      rd_a($urandom_range(0, DA - 1));
      tick();
    end
    idle_a();
    bus_a.iSwap = 1; tick(); bus_a.iSwap = 0;
    repeat (32) begin
      bus_a.iRdEn = 1'($urandom_range(0, 1));
      bus_a.iRdAddr = AW'($urandom_range(0, DA - 1));
      tick();
    end
    idle_a();

    // Mid-fill reset on A: everything returns to reset values.
    bus_a.iWrStart = 1; tick(); bus_a.iWrStart = 0;
    for (int i = 0; i < 5; i++) begin wr_a(i, i); tick(); end
    idle_a();
    rst_a = 1; tick(); rst_a = 0;
    chk("a_rst_rd_ready", 32'(bus_a.oRdReady), 0);
    chk("a_rst_fill_cnt", 32'(bus_a.oFillCount), 0);
    rd_a(3); tick();
    chk("a_rst_read_invalid", 32'(bus_a.oRdValid), 0);
    idle_a();

    // Instance B (DEPTH 500): error cases and mid-fill reset.
    rst_b = 0; tick();
    chk_b_reset("b_init");
    bus_b.iWrStart = 1; tick(); bus_b.iWrStart = 0;
    wr_b(7, 1);
    chk("b_first_cnt", 32'(bus_b.oFillCount), 1);
    chk("b_first_err", 32'(bus_b.oErr), 0);
    wr_b(7, 2);
    chk("b_dup_cnt", 32'(bus_b.oFillCount), 1);
    chk("b_dup_err", 32'(bus_b.oErr), 1);
    wr_b(DB, 3);
    chk("b_oor_cnt", 32'(bus_b.oFillCount), 1);
    wr_b(DB - 1, 4);
    chk("b_last_addr_cnt", 32'(bus_b.oFillCount), 2);
    rst_b = 1; tick(); rst_b = 0;
    chk_b_reset("b_midrst");

    // Full fill of B, start-in-FULL error, swap, range boundary on reads.
    bus_b.iWrStart = 1; tick(); bus_b.iWrStart = 0;
    for (int i = 0; i < DB; i++) wr_b(i, i + 7);
    chk("b_full", 32'(bus_b.oFull), 1);
    chk("b_full_err", 32'(bus_b.oErr), 0);
    bus_b.iWrStart = 1; tick(); bus_b.iWrStart = 0;
    chk("b_start_in_full_err", 32'(bus_b.oErr), 1);
    chk("b_start_in_full_stays", 32'(bus_b.oFull), 1);
    bus_b.iSwap = 1; tick(); bus_b.iSwap = 0;
    bus_b.iRdEn = 1; bus_b.iRdAddr = AW'(DB - 1); tick();
    chk("b_rd_last_valid", 32'(bus_b.oRdValid), 1);
    chk("b_rd_last_data", 32'(bus_b.oRdData), DB - 1 + 7);
    bus_b.iRdAddr = AW'(DB); tick();
    chk("b_rd_oor_valid", 32'(bus_b.oRdValid), 0);
    chk("b_rd_oor_data", 32'(bus_b.oRdData), 0);
    idle_b();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
